// File: rtl/ransac_inlier_scorer_pkg.sv
// Fixed-point types and sizing helpers shared across the RANSAC pipeline.
package ransac_fixed;

    localparam int unsigned VALUE_W = 16;
    localparam int unsigned FRAC_W  = 8;

    // Signed Q8.8 scalar.
    typedef logic signed [VALUE_W-1:0] fixed_t;

    // Plane a*x + b*y + c*z + d = 0.
    typedef struct packed {
        fixed_t a;
        fixed_t b;
        fixed_t c;
        fixed_t d;
    } plane_t;

    localparam int unsigned max_points_default = 65536;

    function automatic int unsigned value_bits();
        return VALUE_W;
    endfunction

    // Counter width able to hold 0..max_points inclusive.
    function automatic int unsigned inlier_count_bits(input int unsigned max_points);
        return $clog2(max_points + 1);
    endfunction

endpackage

// File: rtl/ransac_inlier_scorer_counter.sv
// Saturating up-counter; clr with inc restarts the count at one.
module saturating_counter #(
    parameter int unsigned width = 17,
    parameter int unsigned max   = 65536
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             inc,
    output logic [width-1:0] value
);

    logic [width-1:0] r_value;

    // Count with saturation at max, synchronous reset and restart.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_value <= '0;
        end else if (clr) begin
            r_value <= inc ? width'(1) : '0;
        end else if (inc && (r_value < width'(max))) begin
            r_value <= r_value + width'(1);
        end
    end

    assign value = r_value;

endmodule

// File: rtl/ransac_inlier_scorer.sv
// Scores each candidate plane by inlier count and tracks the best plane seen.
module ransac_inlier_scorer
    import ransac_fixed::*;
#(
    parameter int unsigned max_points = max_points_default
) (
    input  logic                                      clock,
    input  logic                                      reset_n,
    input  logic                                      clear,
    input  fixed_t                                    threshold,
    input  logic                                      in_valid,
    input  fixed_t                                    in_distance,
    input  plane_t                                    in_plane,
    input  logic                                      in_last,
    output logic                                      busy,
    output logic                                      score_valid,
    output logic [inlier_count_bits(max_points)-1:0] score_count,
    output logic [inlier_count_bits(max_points)-1:0] score_points,
    output plane_t                                    score_plane,
    output logic                                      best_valid,
    output logic [inlier_count_bits(max_points)-1:0] best_count,
    output plane_t                                    best_plane,
    output logic                                      best_updated
);

    localparam int unsigned cw = inlier_count_bits(max_points);

    localparam logic S_IDLE  = 1'b0;
    localparam logic S_ACCUM = 1'b1;

    logic          r_state;
    logic          w_state_next;
    logic          w_first;
    logic          w_bit;
    logic          w_score;
    logic          w_cnt_clr;
    logic          w_acc_inc;
    logic          w_pts_inc;
    logic [cw-1:0] w_acc;
    logic [cw-1:0] w_pts;
    logic [cw-1:0] w_acc_base;
    logic [cw-1:0] w_pts_base;
    logic [cw-1:0] w_final;
    logic [cw-1:0] w_final_pts;
    plane_t        w_plane_sel;
    plane_t        r_plane_q;

    logic          r_busy;
    logic          r_score_valid;
    logic [cw-1:0] r_score_count;
    logic [cw-1:0] r_score_points;
    plane_t        r_score_plane;
    logic          r_best_valid;
    logic [cw-1:0] r_best_count;
    plane_t        r_best_plane;
    logic          r_best_updated;

    assign w_first   = (r_state == S_IDLE);
    assign w_bit     = (in_distance <= threshold);
    assign w_score   = in_valid && in_last && !clear;
    assign w_cnt_clr = clear || (w_first && in_valid);
    assign w_acc_inc = in_valid && w_bit && !clear;
    assign w_pts_inc = in_valid && !clear;

    // Totals including the current beat, as the counters would hold them next cycle.
    assign w_acc_base  = w_first ? '0 : w_acc;
    assign w_pts_base  = w_first ? '0 : w_pts;
    assign w_final     = (w_bit && (w_acc_base < cw'(max_points))) ? w_acc_base + cw'(1) : w_acc_base;
    assign w_final_pts = (w_pts_base < cw'(max_points)) ? w_pts_base + cw'(1) : w_pts_base;
    assign w_plane_sel = w_first ? in_plane : r_plane_q;

    saturating_counter #(.width(cw), .max(max_points)) u_acc (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (w_cnt_clr),
        .inc     (w_acc_inc),
        .value   (w_acc)
    );

    saturating_counter #(.width(cw), .max(max_points)) u_pts (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (w_cnt_clr),
        .inc     (w_pts_inc),
        .value   (w_pts)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: open on any beat, close on the last beat, drop on clear.
    always_comb begin
        w_state_next = r_state;
        if (clear) begin
            w_state_next = S_IDLE;
        end else if (in_valid && in_last) begin
            w_state_next = S_IDLE;
        end else if (in_valid) begin
            w_state_next = S_ACCUM;
        end
    end

    // Plane of the open set, taken from its first beat.
    always_ff @(posedge clock) begin
        if (!reset_n || clear) begin
            r_plane_q <= '0;
        end else if (w_first && in_valid) begin
            r_plane_q <= in_plane;
        end
    end

    // Score and best-plane record.
    always_ff @(posedge clock) begin
        if (!reset_n || clear) begin
            r_busy         <= 1'b0;
            r_score_valid  <= 1'b0;
            r_score_count  <= '0;
            r_score_points <= '0;
            r_score_plane  <= '0;
            r_best_valid   <= 1'b0;
            r_best_count   <= '0;
            r_best_plane   <= '0;
            r_best_updated <= 1'b0;
        end else begin
            r_busy         <= (w_state_next == S_ACCUM);
            r_score_valid  <= w_score;
            r_best_updated <= 1'b0;
            if (w_score) begin
                r_score_count  <= w_final;
                r_score_points <= w_final_pts;
                r_score_plane  <= w_plane_sel;
                // Strictly greater: a tie keeps the earlier plane.
                if (!r_best_valid || (w_final > r_best_count)) begin
                    r_best_valid   <= 1'b1;
                    r_best_count   <= w_final;
                    r_best_plane   <= w_plane_sel;
                    r_best_updated <= 1'b1;
                end
            end
        end
    end

    assign busy         = r_busy;
    assign score_valid  = r_score_valid;
    assign score_count  = r_score_count;
    assign score_points = r_score_points;
    assign score_plane  = r_score_plane;
    assign best_valid   = r_best_valid;
    assign best_count   = r_best_count;
    assign best_plane   = r_best_plane;
    assign best_updated = r_best_updated;

endmodule

// File: tb/tb_ransac_inlier_scorer.sv
// Directed bench for ransac_inlier_scorer with a scoreboard of expected scores.
module tb_ransac_inlier_scorer;
    import ransac_fixed::*;

    localparam int MP = 65536;

    typedef struct {
        int     cnt;
        int     pts;
        plane_t plane;
        logic   upd;
        int     bcnt;
        plane_t bplane;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        clear;
    fixed_t      threshold;
    logic        in_valid;
    fixed_t      in_distance;
    plane_t      in_plane;
    logic        in_last;
    logic        busy;
    logic        score_valid;
    logic [16:0] score_count;
    logic [16:0] score_points;
    plane_t      score_plane;
    logic        best_valid;
    logic [16:0] best_count;
    plane_t      best_plane;
    logic        best_updated;

    logic        s_valid;
    fixed_t      s_dist;
    logic        s_last;
    logic        s_clear;
    logic        s_busy;
    logic        s_score_valid;
    logic [2:0]  s_score_count;
    logic [2:0]  s_score_points;
    plane_t      s_score_plane;
    logic        s_best_valid;
    logic [2:0]  s_best_count;
    plane_t      s_best_plane;
    logic        s_best_updated;
    plane_t      s_plane;

    int total = 0;
    int bad   = 0;

    exp_t   q[$];
    logic   m_open = 1'b0;
    int     m_acc = 0;
    int     m_pts = 0;
    plane_t m_plane = '0;
    logic   m_best_valid = 1'b0;
    int     m_best_count = 0;
    plane_t m_best_plane = '0;

    always #5 clock = ~clock;

    ransac_inlier_scorer #(.max_points(MP)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .clear        (clear),
        .threshold    (threshold),
        .in_valid     (in_valid),
        .in_distance  (in_distance),
        .in_plane     (in_plane),
        .in_last      (in_last),
        .busy         (busy),
        .score_valid  (score_valid),
        .score_count  (score_count),
        .score_points (score_points),
        .score_plane  (score_plane),
        .best_valid   (best_valid),
        .best_count   (best_count),
        .best_plane   (best_plane),
        .best_updated (best_updated)
    );

    ransac_inlier_scorer #(.max_points(4)) dut_sat (
        .clock        (clock),
        .reset_n      (reset_n),
        .clear        (s_clear),
        .threshold    (threshold),
        .in_valid     (s_valid),
        .in_distance  (s_dist),
        .in_plane     (s_plane),
        .in_last      (s_last),
        .busy         (s_busy),
        .score_valid  (s_score_valid),
        .score_count  (s_score_count),
        .score_points (s_score_points),
        .score_plane  (s_score_plane),
        .best_valid   (s_best_valid),
        .best_count   (s_best_count),
        .best_plane   (s_best_plane),
        .best_updated (s_best_updated)
    );

    function automatic plane_t pl(input int n);
        plane_t p;
        p.a = fixed_t'(n * 256);
        p.b = fixed_t'(n * 3 + 1);
        p.c = fixed_t'(-n);
        p.d = fixed_t'(n * 17 + 5);
        return p;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; the model predicts, then outputs are checked 1 time unit after the edge.
    task automatic step(input logic v, input fixed_t d, input plane_t p, input logic last,
                        input logic rn, input logic clr);
        int   b;
        exp_t e;
        reset_n     = rn;
        clear       = clr;
        in_valid    = v;
        in_distance = d;
        in_plane    = p;
        in_last     = last;
        if (!rn || clr) begin
            m_open       = 1'b0;
            m_best_valid = 1'b0;
            m_best_count = 0;
            m_best_plane = '0;
        end else if (v) begin
            b = ($signed(d) <= $signed(threshold)) ? 1 : 0;
            if (!m_open) begin
                m_plane = p;
                m_acc   = b;
                m_pts   = 1;
            end else begin
                m_acc = (m_acc + b > MP) ? MP : m_acc + b;
                m_pts = (m_pts + 1 > MP) ? MP : m_pts + 1;
            end
            if (last) begin
                e.cnt   = m_acc;
                e.pts   = m_pts;
                e.plane = m_plane;
                e.upd   = !m_best_valid || (m_acc > m_best_count);
                if (e.upd) begin
                    m_best_valid = 1'b1;
                    m_best_count = m_acc;
                    m_best_plane = m_plane;
                end
                e.bcnt   = m_best_count;
                e.bplane = m_best_plane;
                q.push_back(e);
                m_open = 1'b0;
            end else begin
                m_open = 1'b1;
            end
        end
        @(posedge clock);
        #1;
        check("busy", 128'(busy), 128'(m_open));
        check("best_valid", 128'(best_valid), 128'(m_best_valid));
        if (q.size() > 0) begin
            e = q.pop_front();
            check("score_valid", 128'(score_valid), 128'(1));
            check("score_count", 128'(score_count), 128'(e.cnt));
            check("score_points", 128'(score_points), 128'(e.pts));
            check("score_plane", 128'(score_plane), 128'(e.plane));
            check("best_updated", 128'(best_updated), 128'(e.upd));
            check("best_count", 128'(best_count), 128'(e.bcnt));
            check("best_plane", 128'(best_plane), 128'(e.bplane));
        end else begin
            check("score_valid_idle", 128'(score_valid), 128'(0));
            check("best_updated_idle", 128'(best_updated), 128'(0));
            check("best_count_hold", 128'(best_count), 128'(m_best_count));
        end
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        threshold = fixed_t'(256);
        s_valid   = 1'b0;
        s_dist    = '0;
        s_last    = 1'b0;
        s_clear   = 1'b0;
        s_plane   = pl(40);

        // Reset and check the cleared state.
        step(1'b1, '0, pl(9), 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        check("rst_score_count", 128'(score_count), 128'(0));
        check("rst_score_plane", 128'(score_plane), 128'(0));
        check("rst_best_plane", 128'(best_plane), 128'(0));
        idle();

        // Single-point set scoring as an outlier.
        step(1'b1, fixed_t'(512), pl(1), 1'b1, 1'b1, 1'b0);
        idle();
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

        // Set A: 0.5, 1.0, 1.5, 0.0 -> 3 inliers.
        step(1'b1, fixed_t'(128), pl(2), 1'b0, 1'b1, 1'b0);
        step(1'b1, fixed_t'(256), pl(2), 1'b0, 1'b1, 1'b0);
        step(1'b1, fixed_t'(384), pl(2), 1'b0, 1'b1, 1'b0);
        step(1'b1, fixed_t'(0),   pl(2), 1'b1, 1'b1, 1'b0);
        // Set B back-to-back: tie at 3 keeps plane A.
        step(1'b1, fixed_t'(26), pl(3), 1'b0, 1'b1, 1'b0);
        step(1'b1, fixed_t'(26), pl(3), 1'b0, 1'b1, 1'b0);
        step(1'b1, fixed_t'(26), pl(3), 1'b1, 1'b1, 1'b0);
        // Set C: 4 inliers replaces best.
        for (int i = 0; i < 4; i++) step(1'b1, fixed_t'(10 * i), pl(4), (i == 3), 1'b1, 1'b0);
        idle();

        // Bubbles, mid-set plane change, and a negative distance.
        step(1'b1, fixed_t'(-16), pl(5), 1'b0, 1'b1, 1'b0);
        idle();
        step(1'b1, fixed_t'(300), pl(6), 1'b0, 1'b1, 1'b0);
        idle();
        idle();
        step(1'b1, fixed_t'(100), pl(6), 1'b0, 1'b1, 1'b0);
        step(1'b1, fixed_t'(256), pl(6), 1'b0, 1'b1, 1'b0);
        idle();
        step(1'b1, fixed_t'(512), pl(6), 1'b1, 1'b1, 1'b0);
        idle();

        // Reset during beat 3 aborts the set, then a fresh 2-inlier set.
        step(1'b1, fixed_t'(0), pl(7), 1'b0, 1'b1, 1'b0);
        step(1'b1, fixed_t'(0), pl(7), 1'b0, 1'b1, 1'b0);
        step(1'b1, fixed_t'(0), pl(7), 1'b1, 1'b0, 1'b0);
        idle();
        step(1'b1, fixed_t'(0), pl(8), 1'b0, 1'b1, 1'b0);
        step(1'b1, fixed_t'(0), pl(8), 1'b1, 1'b1, 1'b0);
        idle();

        // Same sequence with clear.
        step(1'b1, fixed_t'(0), pl(10), 1'b0, 1'b1, 1'b0);
        step(1'b1, fixed_t'(0), pl(10), 1'b0, 1'b1, 1'b0);
        step(1'b1, fixed_t'(0), pl(10), 1'b1, 1'b1, 1'b1);
        idle();
        step(1'b1, fixed_t'(0), pl(11), 1'b0, 1'b1, 1'b0);
        step(1'b1, fixed_t'(0), pl(11), 1'b1, 1'b1, 1'b0);
        idle();

        check("queue_drained", 128'(q.size()), 128'(0));

        // Saturation on the max_points=4 instance: 6 inliers score as 4.
        for (int i = 0; i < 6; i++) begin
            s_valid = 1'b1;
            s_dist  = fixed_t'(0);
            s_last  = (i == 5);
            @(posedge clock);
            #1;
            if (i < 5) begin
                check("sat_no_score", 128'(s_score_valid), 128'(0));
                check("sat_busy", 128'(s_busy), 128'(1));
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        check("sat_score_valid", 128'(s_score_valid), 128'(1));
        check("sat_score_count", 128'(s_score_count), 128'(4));
        check("sat_score_points", 128'(s_score_points), 128'(4));
        check("sat_score_plane", 128'(s_score_plane), 128'(pl(40)));
        check("sat_best_valid", 128'(s_best_valid), 128'(1));
        check("sat_best_count", 128'(s_best_count), 128'(4));
        check("sat_best_plane", 128'(s_best_plane), 128'(pl(40)));
        check("sat_best_updated", 128'(s_best_updated), 128'(1));
        @(posedge clock);
        #1;
        check("sat_pulse_end", 128'(s_score_valid), 128'(0));
        check("sat_busy_end", 128'(s_busy), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
